mux_rr_arbiter: RTL and testbench
=================================

Name: mux_rr_arbiter

Overview:
- Round-robin arbiter and select controller that shares one N:1 mux output channel between N valid/ready requesters.
- Registers a one-hot grant and a binary select, and steers the granted requester's data, last and valid onto the shared output.
- Holds a grant until the requester's last beat or a beat limit is reached, then rotates priority.
- Sits in front of any shared downstream consumer, such as a bus or serializer.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- DATA_W, 8, data width per requester.
- MAX_HOLD, 4, maximum beats per grant before forced release (>=1).
- SEL_W, $clog2(N_REQ), select width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- Req_Valid  input  N_REQ  per-requester valid.
- Req_Data  input  N_REQ*DATA_W  packed data, requester i at bits [i*DATA_W +: DATA_W].
- Req_Last  input  N_REQ  per-requester end-of-packet flag.
- Req_Ready  output  N_REQ  per-requester ready.
- Out_Valid  output  1  shared channel valid.
- Out_Data  output  DATA_W  shared channel data.
- Out_Last  output  1  shared channel last.
- Out_Ready  input  1  downstream ready.
- Grant  output  N_REQ  registered one-hot grant.
- Sel  output  SEL_W  registered binary index of Grant.
- Busy  output  1  high while a grant is held.

Behaviour:
- Reset: clk and rst_n only. When rst_n=0 at a rising edge, the block resets.
  - State=IDLE, Grant=0, Sel=0, Busy=0, priority pointer Ptr=0, beat counter Cnt=0.
  - Out_Valid=0, Out_Data=0, Out_Last=0, Req_Ready=0.
  - Reset mid-packet drops the grant immediately; no beat completes in the reset cycle.
- States: IDLE and HOLD.
- IDLE:
  - If any Req_Valid is high, select the first set bit scanning Ptr, Ptr+1, ... N_REQ-1, 0, ... (wrapping).
  - At the next edge: load Grant/Sel with the winner, Cnt=0, go to HOLD, Busy=1.
  - If no request, stay in IDLE.
  - Minimum IDLE duration is one cycle, so request-to-grant latency is exactly 1 cycle.
- HOLD outputs, combinational from the registered Sel:
  - Out_Valid = Req_Valid[Sel].
  - Out_Data = Req_Data[Sel].
  - Out_Last = Req_Last[Sel] & Req_Valid[Sel].
  - Req_Ready[i] = (i==Sel) & Out_Ready; all other Req_Ready bits are 0.
- In IDLE, Out_Valid=0, Out_Data=0, Out_Last=0, Req_Ready=0.
- Beat: Out_Valid & Out_Ready in HOLD. Each beat increments Cnt.
- Release: on a beat where Out_Last=1, or where Cnt==MAX_HOLD-1.
  - At that edge: Grant=0, Busy=0, Ptr=(Sel+1) mod N_REQ, Cnt=0, state goes to IDLE.
  - Sel keeps its value in IDLE (not cleared).
- Stalls:
  - If the granted requester deasserts Req_Valid in HOLD, the grant is held indefinitely with Out_Valid=0. There is no timeout.
  - Out_Ready=0 stalls with the data held by the requester.
- Other requesters' Req_Valid changes during HOLD have no effect until the next IDLE.
- Fairness: after a release, the releasing requester has the lowest priority. With all requesters continuously valid, the grant order is 0,1,2,...,N_REQ-1,0.
- The non-granted Req_Data of any requester never reaches Out_Data.
- Grant is always zero or one-hot, and Sel always equals the index of Grant while Busy=1.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with Req_Valid=4'b1111. All outputs must be 0 and Grant=0. After release, Grant=4'b0001 appears 1 cycle later and Sel=0.
- Single packet: requester 2 sends 3 beats 0xA1, 0xA2, 0xA3 with last on 0xA3 and Out_Ready=1.
  - Out_Data must show A1, A2, A3 on consecutive cycles and Out_Last must be high only on A3.
  - Then Busy=0 and Ptr=3.
- Rotation: all four requesters continuously valid, each with Req_Last=1 on every beat. The Grant sequence must be 0001, 0010, 0100, 1000, 0001, with one IDLE cycle between grants.
- MAX_HOLD: requester 1 is valid with last never set, and requester 3 is also valid.
  - After exactly 4 beats, requester 1 is released and requester 3 is granted next.
- Backpressure and stall:
  - Out_Ready=0 for 3 cycles mid-packet: Out_Data stays stable and Cnt does not advance.
  - Granted requester drops valid for 2 cycles: Grant is held and Out_Valid=0.
- Reset mid-packet: assert rst_n=0 after beat 2 of 4. All outputs are 0 the next cycle. After reset, arbitration restarts from Ptr=0.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that shares one N:1 valid/ready channel between N_REQ requesters.
// A grant is held until the requester's last beat or MAX_HOLD beats, then priority rotates.
module mux_rr_arbiter #(
   parameter int N_REQ    = 4,
   parameter int DATA_W   = 8,
   parameter int MAX_HOLD = 4,
   localparam int SEL_W   = $clog2(N_REQ)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_REQ-1:0]          Req_Valid,
   input  logic [N_REQ*DATA_W-1:0]   Req_Data,
   input  logic [N_REQ-1:0]          Req_Last,
   output logic [N_REQ-1:0]          Req_Ready,
   output logic                      Out_Valid,
   output logic [DATA_W-1:0]         Out_Data,
   output logic                      Out_Last,
   input  logic                      Out_Ready,
   output logic [N_REQ-1:0]          Grant,
   output logic [SEL_W-1:0]          Sel,
   output logic                      Busy
);

   localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_REQ - 1);
   localparam logic [CNT_W-1:0] CNT_LIM  = CNT_W'(MAX_HOLD - 1);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t             state_q, state_d;
   logic [N_REQ-1:0]   grant_q, grant_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [SEL_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               found;
   logic [SEL_W-1:0]   win;
   logic               sel_valid;
   logic [DATA_W-1:0]  sel_data;
   logic               sel_last;
   logic               beat;
   logic               release_now;

   // Reverse scan so the requester closest to ptr_q is the last assignment and wins.
   always_comb begin
      int idx;
      logic [SEL_W-1:0] cand;
      found = 1'b0;
      win   = ptr_q;
      idx   = 0;
      cand  = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = int'(ptr_q) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         cand = SEL_W'(idx);
         if (Req_Valid[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   always_comb begin
      sel_valid = 1'b0;
      sel_data  = '0;
      sel_last  = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (sel_q == SEL_W'(i)) begin
            sel_valid = Req_Valid[i];
            sel_data  = Req_Data[i*DATA_W +: DATA_W];
            sel_last  = Req_Last[i];
         end
      end
   end

   assign beat        = (state_q == HOLD) && sel_valid && Out_Ready;
   assign release_now = beat && (sel_last || (cnt_q == CNT_LIM));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         sel_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   // Sel is deliberately left unchanged on release; only Grant/Busy drop.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               grant_d      = '0;
               grant_d[win] = 1'b1;
               sel_d        = win;
               cnt_d        = '0;
               state_d      = HOLD;
            end
         end
         HOLD: begin
            if (release_now) begin
               grant_d = '0;
               ptr_d   = (sel_q == LAST_IDX) ? '0 : sel_q + 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end else if (beat) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      Out_Valid = 1'b0;
      Out_Data  = '0;
      Out_Last  = 1'b0;
      Req_Ready = '0;
      if (state_q == HOLD) begin
         Out_Valid = sel_valid;
         Out_Data  = sel_data;
         Out_Last  = sel_last & sel_valid;
         for (int i = 0; i < N_REQ; i++) begin
            Req_Ready[i] = (sel_q == SEL_W'(i)) & Out_Ready;
         end
      end
   end

   assign Grant = grant_q;
   assign Sel   = sel_q;
   assign Busy  = (state_q == HOLD);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: reset, single packet, rotation, beat limit,
// backpressure/valid stall and mid-packet reset, with hand-computed expectations.
module tb_mux_rr_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  req_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_last;
   logic        out_ready;
   logic [3:0]  grant;
   logic [1:0]  sel;
   logic        busy;

   int checks;
   int failures;

   logic [3:0] rot_exp [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                               4'b0000, 4'b1000, 4'b0000, 4'b0001};

   mux_rr_arbiter #(.N_REQ(4), .DATA_W(8), .MAX_HOLD(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .Req_Valid (req_valid),
      .Req_Data  (req_data),
      .Req_Last  (req_last),
      .Req_Ready (req_ready),
      .Out_Valid (out_valid),
      .Out_Data  (out_data),
      .Out_Last  (out_last),
      .Out_Ready (out_ready),
      .Grant     (grant),
      .Sel       (sel),
      .Busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_data(input int i, input logic [7:0] v);
      req_data[i*8 +: 8] = v;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_grant"}, {28'd0, grant}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_ovalid"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_odata"}, {24'd0, out_data}, 32'd0);
      chk({tag, "_olast"}, {31'd0, out_last}, 32'd0);
      chk({tag, "_rready"}, {28'd0, req_ready}, 32'd0);
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = 4'b0000;
      req_last  = 4'b0000;
      req_data  = 32'h13121110;
      out_ready = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst_n     = 1'b0;
      req_valid = 4'b1111;
      req_data  = 32'h13121110;
      req_last  = 4'b0000;
      out_ready = 1'b1;

      // Reset held two cycles with every requester valid
      tick(); settle();
      chk_idle("rst_c1");
      chk("rst_sel", {30'd0, sel}, 32'd0);
      tick(); settle();
      chk_idle("rst_c2");
      rst_n = 1'b1;
      tick(); settle();
      chk("rst_first_grant", {28'd0, grant}, 32'h1);
      chk("rst_first_sel", {30'd0, sel}, 32'd0);
      chk("rst_first_busy", {31'd0, busy}, 32'd1);
      chk("rst_first_data", {24'd0, out_data}, 32'h10);
      chk("rst_first_rready", {28'd0, req_ready}, 32'h1);

      // Single three-beat packet from requester 2
      do_reset();
      req_valid = 4'b0100;
      set_data(2, 8'hA1);
      tick(); settle();
      chk("pkt_grant", {28'd0, grant}, 32'h4);
      chk("pkt_sel", {30'd0, sel}, 32'd2);
      chk("pkt_d1", {24'd0, out_data}, 32'hA1);
      chk("pkt_l1", {31'd0, out_last}, 32'd0);
      tick();
      set_data(2, 8'hA2);
      settle();
      chk("pkt_d2", {24'd0, out_data}, 32'hA2);
      chk("pkt_l2", {31'd0, out_last}, 32'd0);
      tick();
      set_data(2, 8'hA3);
      req_last = 4'b0100;
      settle();
      chk("pkt_d3", {24'd0, out_data}, 32'hA3);
      chk("pkt_l3", {31'd0, out_last}, 32'd1);
      chk("pkt_rready", {28'd0, req_ready}, 32'h4);
      tick();
      req_last  = 4'b0000;
      req_valid = 4'b1111;
      req_data  = 32'h13121110;
      settle();
      chk_idle("pkt_rel");
      chk("pkt_sel_kept", {30'd0, sel}, 32'd2);
      tick(); settle();
      chk("pkt_ptr3_grant", {28'd0, grant}, 32'h8);
      chk("pkt_ptr3_sel", {30'd0, sel}, 32'd3);
      chk("pkt_ptr3_data", {24'd0, out_data}, 32'h13);

      // Rotation with all requesters valid and last on every beat
      do_reset();
      req_valid = 4'b1111;
      req_last  = 4'b1111;
      for (int i = 0; i < 9; i++) begin
         tick(); settle();
         chk($sformatf("rot_grant%0d", i), {28'd0, grant}, {28'd0, rot_exp[i]});
         chk($sformatf("rot_last%0d", i), {31'd0, out_last}, {31'd0, (rot_exp[i] != 4'b0000)});
      end

      // Beat limit: requester 1 never sends last, requester 3 waiting
      do_reset();
      req_valid = 4'b1010;
      tick(); settle();
      chk("mh_grant", {28'd0, grant}, 32'h2);
      for (int i = 0; i < 3; i++) begin
         tick(); settle();
         chk($sformatf("mh_hold%0d", i), {28'd0, grant}, 32'h2);
      end
      tick(); settle();
      chk_idle("mh_rel");
      tick(); settle();
      chk("mh_next_grant", {28'd0, grant}, 32'h8);
      chk("mh_next_data", {24'd0, out_data}, 32'h13);

      // Backpressure for three cycles, then granted requester drops valid
      do_reset();
      req_valid = 4'b0001;
      set_data(0, 8'h55);
      tick(); settle();
      chk("bp_grant", {28'd0, grant}, 32'h1);
      chk("bp_d0", {24'd0, out_data}, 32'h55);
      tick();
      set_data(0, 8'h66);
      out_ready = 1'b0;
      settle();
      chk("bp_rready", {28'd0, req_ready}, 32'h0);
      chk("bp_d1", {24'd0, out_data}, 32'h66);
      for (int i = 0; i < 3; i++) begin
         tick(); settle();
         chk($sformatf("bp_stall_data%0d", i), {24'd0, out_data}, 32'h66);
         chk($sformatf("bp_stall_grant%0d", i), {28'd0, grant}, 32'h1);
      end
      out_ready = 1'b1;
      tick();
      req_valid = 4'b0000;
      settle();
      chk("st_ovalid0", {31'd0, out_valid}, 32'd0);
      chk("st_grant0", {28'd0, grant}, 32'h1);
      chk("st_busy0", {31'd0, busy}, 32'd1);
      tick(); settle();
      chk("st_ovalid1", {31'd0, out_valid}, 32'd0);
      chk("st_grant1", {28'd0, grant}, 32'h1);
      tick();
      req_valid = 4'b0001;
      settle();
      chk("st_resume_grant", {28'd0, grant}, 32'h1);
      chk("st_resume_ovalid", {31'd0, out_valid}, 32'd1);
      tick(); settle();
      chk("st_cnt_hold", {28'd0, grant}, 32'h1);
      tick(); settle();
      chk("st_release_grant", {28'd0, grant}, 32'h0);
      chk("st_release_busy", {31'd0, busy}, 32'd0);

      // Reset after beat 2 of a four-beat packet
      do_reset();
      req_valid = 4'b0100;
      tick(); settle();
      chk("mr_grant", {28'd0, grant}, 32'h4);
      tick();
      tick();
      rst_n = 1'b0;
      tick(); settle();
      chk_idle("mr_rst");
      chk("mr_sel", {30'd0, sel}, 32'd0);
      rst_n     = 1'b1;
      req_valid = 4'b1111;
      tick(); settle();
      chk("mr_restart_grant", {28'd0, grant}, 32'h1);
      chk("mr_restart_sel", {30'd0, sel}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
